// File: rtl/sf_pkg.sv
`default_nettype none
// ============================================================================
//  Package : sf_pkg
//  Shared constants for the controller_inputs bit map used by the input
//  conditioner and by game, plus the raw-pin ordering inside the conditioner.
//  Revision: 1.0  initial release
// ============================================================================
package sf_pkg;

   // controller_inputs bit map
   localparam int CI_LEFT      = 0;
   localparam int CI_RIGHT     = 1;
   localparam int CI_UP        = 2;
   localparam int CI_DOWN      = 3;
   localparam int CI_ATK_PULSE = 4;
   localparam int CI_ATK_HELD  = 5;
   localparam int CI_SHD_HELD  = 6;
   localparam int CI_W         = 7;

   // Order of the normalised (active-high) pins inside the conditioner
   localparam int PIN_LEFT   = 0;
   localparam int PIN_RIGHT  = 1;
   localparam int PIN_UP     = 2;
   localparam int PIN_DOWN   = 3;
   localparam int PIN_ATTACK = 4;
   localparam int PIN_SHIELD = 5;
   localparam int NUM_PINS   = 6;

   // Opposing directions held together cancel to neutral; returns {b, a}
   function automatic logic [1:0] resolve_axis(input logic a, input logic b);
      return (a & b) ? 2'b00 : {b, a};
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Interface : input_conditioner_if
//  Raw player pins in, conditioned controller_inputs vector out.
//  Revision: 1.0  initial release
// ============================================================================
interface input_conditioner_if;
   import sf_pkg::*;

   logic            left_l;
   logic            right_l;
   logic            up_l;
   logic            down_l;
   logic            attack;
   logic            shield;
   logic [CI_W-1:0] controller_inputs;

   // Pin driver side (board / bench)
   modport master (
      output left_l, right_l, up_l, down_l, attack, shield,
      input  controller_inputs
   );

   // Conditioner side
   modport slave (
      input  left_l, right_l, up_l, down_l, attack, shield,
      output controller_inputs
   );

endinterface
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module  : debounce_bit
//  Two-flop synchroniser followed by a stability counter; the output level
//  only follows the input once it has held for DEBOUNCE_CYCLES clocks.
//  Revision: 1.0  initial release
// ============================================================================
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  wire logic clk,
   input  wire logic rst_l,
   input  wire logic i_pin,
   output logic      o_stable
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise the asynchronous pin into clk
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_pin;
         r_s2 <= r_s1;
      end
   end

   // Count consecutive cycles of disagreement; any return to the stable level restarts
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_s2 == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
         r_stable <= r_s2;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : input_conditioner
//  One player's joystick/buttons: normalise, synchronise, debounce, resolve
//  opposing directions (SOCD neutral), detect attack press, register output.
//  Revision: 1.0  initial release
// ============================================================================
module input_conditioner
   import sf_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  wire logic              clk,
   input  wire logic              rst_l,
   input_conditioner_if.slave     bus
);

   logic [NUM_PINS-1:0] w_pin;
   logic [NUM_PINS-1:0] w_stable;
   logic [CI_W-1:0]     w_next;
   logic                r_atk_prev;
   logic [CI_W-1:0]     r_ci;

   // Directions are active-low on the connector; flip so released reads 0
   assign w_pin[PIN_LEFT]   = ~bus.left_l;
   assign w_pin[PIN_RIGHT]  = ~bus.right_l;
   assign w_pin[PIN_UP]     = ~bus.up_l;
   assign w_pin[PIN_DOWN]   = ~bus.down_l;
   assign w_pin[PIN_ATTACK] =  bus.attack;
   assign w_pin[PIN_SHIELD] =  bus.shield;

   generate
      for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_db
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_db (
            .clk      (clk),
            .rst_l    (rst_l),
            .i_pin    (w_pin[gi]),
            .o_stable (w_stable[gi])
         );
      end
   endgenerate

   // Resolve each axis independently and build the next output word
   always_comb begin
      w_next = '0;
      {w_next[CI_RIGHT], w_next[CI_LEFT]} = resolve_axis(w_stable[PIN_LEFT], w_stable[PIN_RIGHT]);
      {w_next[CI_DOWN],  w_next[CI_UP]}   = resolve_axis(w_stable[PIN_UP],   w_stable[PIN_DOWN]);
      w_next[CI_ATK_PULSE] = w_stable[PIN_ATTACK] & ~r_atk_prev;
      w_next[CI_ATK_HELD]  = w_stable[PIN_ATTACK];
      w_next[CI_SHD_HELD]  = w_stable[PIN_SHIELD];
   end

   // Register the output word and remember attack level for press detection
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_atk_prev <= 1'b0;
         r_ci       <= '0;
      end else begin
         r_atk_prev <= w_stable[PIN_ATTACK];
         r_ci       <= w_next;
      end
   end

   assign bus.controller_inputs = r_ci;

endmodule
`default_nettype wire
